axi_lite_reg_bridge: RTL and testbench

AXI4-Lite slave that sits directly upstream of the custom peripheral register interface. It turns bus writes into per-channel reg2ip data/valid transfers with a ready handshake, and captures per-channel ip2reg data into readable shadow registers. It also exposes a status word. Placed between the SoC AXI-Lite interconnect port and the custom IP.

---
 rtl/axi_lite_reg_bridge_pkg.sv | 30 +++
 rtl/axi_lite_reg_chan.sv | 61 ++++++
 rtl/axi_lite_reg_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_reg_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_reg_bridge_pkg.sv
// Shared types and address-map helpers for the AXI4-Lite to custom-IP register bridge.
package axi_lite_reg_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  typedef enum logic [1:0] {REG_NONE, REG_WR, REG_RD, REG_STAT} region_e;

  typedef struct packed {
    region_e    region;
    logic [7:0] idx;
  } dec_t;

  function automatic int wr_chan_off(input int n);
    return 4 * n;
  endfunction

  function automatic int rd_chan_off(input int nch, input int n);
    return 4 * (nch + n);
  endfunction

  function automatic int status_off(input int nch);
    return 8 * nch;
  endfunction

endpackage

// File: rtl/axi_lite_reg_chan.sv
// One bridge channel: write shadow with byte-strobe merge and valid/ready toward the IP,
// plus the captured ip2reg value with its fresh flag.
module axi_lite_reg_chan #(
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  input  logic            cap_en_i,
  input  logic [DW-1:0]   cap_data_i,
  input  logic            rd_clr_i,
  output logic [DW-1:0]   rd_data_o,
  output logic            fresh_o
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q;
  logic [DW-1:0] rd_q;
  logic          fresh_q;

  always_comb begin
    data_d = data_q;
    for (int b = 0; b < DW / 8; b++) begin
      if (wstrb_i[b]) data_d[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
      fresh_q <= 1'b0;
    end else begin
      // The top only raises we_i while valid_q is low, so the two branches never collide.
      if (we_i) begin
        data_q  <= data_d;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      if (cap_en_i) begin
        rd_q    <= cap_data_i;
        fresh_q <= 1'b1;
      end else if (rd_clr_i) begin
        fresh_q <= 1'b0;
      end
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign rd_data_o = rd_q;
  assign fresh_o   = fresh_q;

endmodule

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave bridging bus writes to per-channel reg2ip transfers and exposing
// captured ip2reg values plus a status word. Handshake: a beat transfers on the rising
// edge where valid and ready are both high; valid, once raised, holds until that edge.
module axi_lite_reg_bridge
  import axi_lite_reg_bridge_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DW  = 32,
  parameter int AW  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AW-1:0]     s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DW-1:0]     s_wdata,
  input  logic [DW/8-1:0]   s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [AW-1:0]     s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DW-1:0]     s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [NCH*DW-1:0] reg2ip_data,
  output logic [NCH-1:0]    reg2ip_valid,
  input  logic [NCH-1:0]    reg2ip_ready,
  input  logic [NCH*DW-1:0] ip2reg_data,
  input  logic [NCH-1:0]    ip2reg_en
);

  function automatic dec_t decode(input logic [AW-1:0] addr);
    dec_t d;
    int   off;
    off = int'(addr) & ~3;
    d   = '{region: REG_NONE, idx: '0};
    for (int n = 0; n < NCH; n++) begin
      if (off == wr_chan_off(n))      d = '{region: REG_WR, idx: 8'(n)};
      if (off == rd_chan_off(NCH, n)) d = '{region: REG_RD, idx: 8'(n)};
    end
    if (off == status_off(NCH)) d = '{region: REG_STAT, idx: '0};
    return d;
  endfunction

  wr_state_e       wr_state_q;
  logic            aw_done_q, w_done_q;
  logic [AW-1:0]   awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wstrb_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;

  rd_state_e       rd_state_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;

  logic [DW-1:0]   rdq_w [NCH];
  logic [NCH-1:0]  fresh_w;
  logic [NCH-1:0]  ch_we, rd_clr;

  logic            aw_hs, w_hs, ar_hs, wr_go;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data, rd_data, status;
  logic [DW/8-1:0] wr_strb;
  logic [1:0]      wr_resp, rd_resp;
  dec_t            wdec, rdec;

  assign s_awready = !rst_i && (wr_state_q == W_IDLE) && !aw_done_q;
  assign s_wready  = !rst_i && (wr_state_q == W_IDLE) && !w_done_q;
  assign s_arready = !rst_i && (rd_state_q == R_IDLE);
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign ar_hs     = s_arvalid && s_arready;

  // The write commits on the edge of whichever AW/W beat arrives last, using bus values
  // directly for the beat landing now and latched values for the earlier one.
  assign wr_go   = (wr_state_q == W_IDLE) && (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign wr_addr = aw_done_q ? awaddr_q : s_awaddr;
  assign wr_data = w_done_q ? wdata_q : s_wdata;
  assign wr_strb = w_done_q ? wstrb_q : s_wstrb;
  assign wdec    = decode(wr_addr);
  assign rdec    = decode(s_araddr);

  always_comb begin
    wr_resp = RESP_DECERR;
    ch_we   = '0;
    case (wdec.region)
      REG_WR: begin
        wr_resp = RESP_SLVERR;
        for (int n = 0; n < NCH; n++) begin
          if (wdec.idx == 8'(n) && !reg2ip_valid[n]) begin
            wr_resp  = RESP_OKAY;
            ch_we[n] = wr_go;
          end
        end
      end
      REG_RD, REG_STAT: wr_resp = RESP_SLVERR;
      default:          wr_resp = RESP_DECERR;
    endcase
  end

  always_comb begin
    status          = '0;
    status[NCH-1:0] = reg2ip_valid;
    status[8 +: NCH] = fresh_w;
    rd_data = '0;
    rd_resp = RESP_OKAY;
    rd_clr  = '0;
    case (rdec.region)
      REG_WR: begin
        for (int n = 0; n < NCH; n++) begin
          if (rdec.idx == 8'(n)) rd_data = reg2ip_data[n*DW +: DW];
        end
      end
      REG_RD: begin
        for (int n = 0; n < NCH; n++) begin
          if (rdec.idx == 8'(n)) begin
            rd_data   = rdq_w[n];
            rd_clr[n] = ar_hs;
          end
        end
      end
      REG_STAT: rd_data = status;
      default:  rd_resp = RESP_DECERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (wr_go) begin
            wr_state_q <= W_RESP;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_resp;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_done_q <= 1'b1;
              awaddr_q  <= s_awaddr;
            end
            if (w_hs) begin
              w_done_q <= 1'b1;
              wdata_q  <= s_wdata;
              wstrb_q  <= s_wstrb;
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state_q <= R_DATA;
            rvalid_q   <= 1'b1;
            rresp_q    <= rd_resp;
            rdata_q    <= rd_data;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rresp  = rresp_q;
  assign s_rdata  = rdata_q;

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    axi_lite_reg_chan #(.DW(DW)) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (ch_we[n]),
      .wdata_i    (wr_data),
      .wstrb_i    (wr_strb),
      .ready_i    (reg2ip_ready[n]),
      .valid_o    (reg2ip_valid[n]),
      .data_o     (reg2ip_data[n*DW +: DW]),
      .cap_en_i   (ip2reg_en[n]),
      .cap_data_i (ip2reg_data[n*DW +: DW]),
      .rd_clr_i   (rd_clr[n]),
      .rd_data_o  (rdq_w[n]),
      .fresh_o    (fresh_w[n])
    );
  end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed bench for axi_lite_reg_bridge: a vector table for single transactions plus
// hand-timed sequences for latency, simultaneous capture/read and reset corner cases.
module tb_axi_lite_reg_bridge;

  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [AW-1:0]     s_awaddr = '0;
  logic              s_awvalid = 1'b0;
  logic              s_awready;
  logic [DW-1:0]     s_wdata = '0;
  logic [3:0]        s_wstrb = '0;
  logic              s_wvalid = 1'b0;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready = 1'b0;
  logic [AW-1:0]     s_araddr = '0;
  logic              s_arvalid = 1'b0;
  logic              s_arready;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready = 1'b0;
  logic [NCH*DW-1:0] reg2ip_data;
  logic [NCH-1:0]    reg2ip_valid;
  logic [NCH-1:0]    reg2ip_ready = '0;
  logic [NCH*DW-1:0] ip2reg_data = '0;
  logic [NCH-1:0]    ip2reg_en = '0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  axi_lite_reg_bridge #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg2ip_data(reg2ip_data), .reg2ip_valid(reg2ip_valid), .reg2ip_ready(reg2ip_ready),
    .ip2reg_data(ip2reg_data), .ip2reg_en(ip2reg_en)
  );

  typedef struct {
    bit          is_wr;
    logic [2:0]  rdy;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_p, w_p, aw_h, w_h, got;
    int cyc;
    s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; cyc = 0; resp = 2'bxx;
    while ((aw_p || w_p) && cyc < 40) begin
      @(negedge clk);
      aw_h = s_awvalid && s_awready;
      w_h  = s_wvalid && s_wready;
      step();
      if (aw_h) begin s_awvalid = 1'b0; aw_p = 1'b0; end
      if (w_h) begin s_wvalid = 1'b0; w_p = 1'b0; end
      cyc++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1; got = 1'b0; cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (s_bvalid) begin got = 1'b1; resp = s_bresp; end
      step();
      cyc++;
    end
    s_bready = 1'b0;
    if (!got || aw_p || w_p) timeout("axi_write");
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_h, got;
    int cyc;
    s_araddr = a; s_arvalid = 1'b1; ar_h = 1'b0; cyc = 0; d = 'x; resp = 2'bxx;
    while (!ar_h && cyc < 40) begin
      @(negedge clk);
      ar_h = s_arvalid && s_arready;
      step();
      cyc++;
    end
    s_arvalid = 1'b0;
    s_rready = 1'b1; got = 1'b0; cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (s_rvalid) begin got = 1'b1; d = s_rdata; resp = s_rresp; end
      step();
      cyc++;
    end
    s_rready = 1'b0;
    if (!got || !ar_h) timeout("axi_read");
  endtask

  task automatic pulse_ready(input logic [2:0] mask);
    if (mask != 3'b000) begin
      reg2ip_ready = mask;
      step();
      reg2ip_ready = '0;
    end
  endtask

  task automatic capture(input int ch, input logic [31:0] d);
    ip2reg_data[ch*32 +: 32] = d;
    ip2reg_en[ch] = 1'b1;
    step();
    ip2reg_en = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 3'b000, 5'h00, 32'h11111111, 4'hF, OKAY,   32'h0,        "w_ch0"};
    vecs[1]  = '{1'b1, 3'b000, 5'h00, 32'h00000001, 4'hF, SLVERR, 32'h0,        "w_ch0_busy"};
    vecs[2]  = '{1'b0, 3'b000, 5'h00, 32'h0,        4'h0, OKAY,   32'h11111111, "r_ch0_unchanged"};
    vecs[3]  = '{1'b1, 3'b000, 5'h08, 32'hAABBCCDD, 4'hF, OKAY,   32'h0,        "w_ch2_full"};
    vecs[4]  = '{1'b1, 3'b100, 5'h08, 32'h00001234, 4'h3, OKAY,   32'h0,        "w_ch2_strb3"};
    vecs[5]  = '{1'b0, 3'b000, 5'h08, 32'h0,        4'h0, OKAY,   32'hAABB1234, "r_ch2_merge"};
    vecs[6]  = '{1'b0, 3'b000, 5'h0B, 32'h0,        4'h0, OKAY,   32'hAABB1234, "r_ch2_lowbits"};
    vecs[7]  = '{1'b0, 3'b000, 5'h1C, 32'h0,        4'h0, DECERR, 32'h0,        "r_unmapped"};
    vecs[8]  = '{1'b1, 3'b000, 5'h1C, 32'h5A5A5A5A, 4'hF, DECERR, 32'h0,        "w_unmapped"};
    vecs[9]  = '{1'b1, 3'b000, 5'h10, 32'hFFFFFFFF, 4'hF, SLVERR, 32'h0,        "w_rdchan"};
    vecs[10] = '{1'b1, 3'b000, 5'h18, 32'hFFFFFFFF, 4'hF, SLVERR, 32'h0,        "w_status"};
    vecs[11] = '{1'b0, 3'b000, 5'h18, 32'h0,        4'h0, OKAY,   32'h00000005, "r_status"};
    vecs[12] = '{1'b0, 3'b000, 5'h10, 32'h0,        4'h0, OKAY,   32'h00000000, "r_rdchan1"};
    vecs[13] = '{1'b0, 3'b000, 5'h04, 32'h0,        4'h0, OKAY,   32'hDEADBEEF, "r_ch1_shadow"};

    // Reset: readies forced low while rst_i is high, everything else zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(s_awready), 32'h0);
    check("rst_wready", 32'(s_wready), 32'h0);
    check("rst_arready", 32'(s_arready), 32'h0);
    check("rst_bvalid", 32'(s_bvalid), 32'h0);
    check("rst_rvalid", 32'(s_rvalid), 32'h0);
    check("rst_reg2ip_valid", 32'(reg2ip_valid), 32'h0);
    for (int n = 0; n < NCH; n++) check("rst_reg2ip_data", reg2ip_data[n*32 +: 32], 32'h0);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check("rel_awready", 32'(s_awready), 32'h1);
    check("rel_wready", 32'(s_wready), 32'h1);
    check("rel_arready", 32'(s_arready), 32'h1);
    check("rel_rdata", s_rdata, 32'h0);
    check("rel_bresp", 32'(s_bresp), 32'h0);
    step();

    // Downstream handshake on channel 1.
    axi_write(5'h04, 32'hDEADBEEF, 4'hF, resp);
    check("w_ch1_resp", 32'(resp), 32'(OKAY));
    check("w_ch1_data", reg2ip_data[32 +: 32], 32'hDEADBEEF);
    check("w_ch1_valid", 32'(reg2ip_valid), 32'h2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ch1_valid_hold", 32'(reg2ip_valid[1]), 32'h1);
      step();
    end
    pulse_ready(3'b010);
    @(negedge clk);
    check("ch1_valid_clear", 32'(reg2ip_valid[1]), 32'h0);
    step();

    for (int i = 0; i < 14; i++) begin
      pulse_ready(vecs[i].rdy);
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check({vecs[i].name, "_resp"}, 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        check({vecs[i].name, "_resp"}, 32'(resp), 32'(vecs[i].exp_resp));
        check({vecs[i].name, "_data"}, rd, vecs[i].exp_rdata);
      end
    end

    // Capture then clear-on-read of read channel 0; STATUS read does not clear.
    capture(0, 32'h00002468);
    axi_read(5'h18, rd, resp);
    check("status_fresh0", rd, 32'h00000105);
    axi_read(5'h0C, rd, resp);
    check("r_rd0_data", rd, 32'h00002468);
    check("r_rd0_resp", 32'(resp), 32'(OKAY));
    axi_read(5'h18, rd, resp);
    check("status_cleared", rd, 32'h00000005);

    // Capture and AR on read channel 2 in the same cycle.
    capture(2, 32'h00001357);
    axi_read(5'h14, rd, resp);
    check("r_rd2_old", rd, 32'h00001357);
    s_araddr = 5'h14; s_arvalid = 1'b1;
    ip2reg_data[64 +: 32] = 32'h000048D0; ip2reg_en[2] = 1'b1;
    @(negedge clk);
    check("simul_arready", 32'(s_arready), 32'h1);
    step();
    s_arvalid = 1'b0; ip2reg_en = '0; s_rready = 1'b1;
    @(negedge clk);
    check("simul_rvalid", 32'(s_rvalid), 32'h1);
    check("simul_rdata", s_rdata, 32'h00001357);
    step();
    s_rready = 1'b0;
    axi_read(5'h18, rd, resp);
    check("simul_status", rd, 32'h00000405);
    axi_read(5'h14, rd, resp);
    check("r_rd2_new", rd, 32'h000048D0);

    // AW three cycles ahead of W, bready held low for 4 cycles.
    s_awaddr = 5'h04; s_awvalid = 1'b1;
    @(negedge clk);
    check("awfirst_awready", 32'(s_awready), 32'h1);
    step();
    s_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("awfirst_awready_low", 32'(s_awready), 32'h0);
      check("awfirst_no_bvalid", 32'(s_bvalid), 32'h0);
      step();
    end
    s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    check("awfirst_wready", 32'(s_wready), 32'h1);
    step();
    s_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("awfirst_bvalid_hold", 32'(s_bvalid), 32'h1);
      check("awfirst_ready_low", 32'({s_awready, s_wready}), 32'h0);
      if (i == 0) begin
        check("awfirst_bresp", 32'(s_bresp), 32'(OKAY));
        check("awfirst_data", reg2ip_data[32 +: 32], 32'hCAFEF00D);
        check("awfirst_valid", 32'(reg2ip_valid[1]), 32'h1);
      end
      step();
    end
    s_bready = 1'b1;
    @(negedge clk);
    check("awfirst_bhs", 32'(s_bvalid), 32'h1);
    step();
    s_bready = 1'b0;
    @(negedge clk);
    check("awfirst_bvalid_done", 32'(s_bvalid), 32'h0);
    check("awfirst_ready_back", 32'({s_awready, s_wready}), 32'h3);
    step();
    pulse_ready(3'b010);

    // W ahead of AW, then reset while in W_RESP.
    s_wdata = 32'h00000055; s_wstrb = 4'h1; s_wvalid = 1'b1;
    @(negedge clk);
    check("wfirst_wready", 32'(s_wready), 32'h1);
    step();
    s_wvalid = 1'b0;
    @(negedge clk);
    check("wfirst_ready_split", 32'({s_awready, s_wready}), 32'h2);
    step();
    s_awaddr = 5'h04; s_awvalid = 1'b1;
    step();
    s_awvalid = 1'b0;
    @(negedge clk);
    check("wfirst_bvalid", 32'(s_bvalid), 32'h1);
    check("wfirst_merge", reg2ip_data[32 +: 32], 32'hCAFEF055);
    step();
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_awready", 32'(s_awready), 32'h0);
    step();
    @(negedge clk);
    check("midrst_bvalid", 32'(s_bvalid), 32'h0);
    check("midrst_valid", 32'(reg2ip_valid), 32'h0);
    check("midrst_data1", reg2ip_data[32 +: 32], 32'h0);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check("postrst_awready", 32'(s_awready), 32'h1);
    check("postrst_bvalid", 32'(s_bvalid), 32'h0);
    step();
    axi_read(5'h18, rd, resp);
    check("postrst_status", rd, 32'h00000000);
    axi_write(5'h08, 32'h0000BEEF, 4'hF, resp);
    check("postrst_write", 32'(resp), 32'(OKAY));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
